// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic PORT_CORE   = 1'b0;
    localparam logic PORT_LOADER = 1'b1;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational 2-way request picker.
// DMEM_ARB_RR_EN selects round-robin on ties; otherwise port 0 always wins.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic sel,
    output logic any
);

    assign any = req0 | req1;

`ifdef DMEM_ARB_RR_EN
    // On a tie the port not granted last time wins.
    assign sel = (req0 && req1) ? ~last : (req0 ? PORT_CORE : PORT_LOADER);
`else
    logic unused_last;
    assign unused_last = last;
    assign sel = req0 ? PORT_CORE : PORT_LOADER;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and one-access-per-three-cycles sequencer for data_mem.
// DMEM_ARB_RR_EN enables round-robin tie-breaking (default: fixed priority, port 0).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic [31:0]       mem_address,
    output logic              mem_wr_en,
    output logic              mem_read_en,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam logic [IDX_W:0] DEPTH_LIM = (IDX_W + 1)'(MEM_DEPTH);

    state_t state, state_next;

    logic pick_sel, pick_any, last, grant;

    logic              req_we, req_err;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              we_q, err_q, owner_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;

    dmem_arb_pick u_pick (
        .req0 (req0),
        .req1 (req1),
        .last (last),
        .sel  (pick_sel),
        .any  (pick_any)
    );

    assign grant = (state == IDLE) && pick_any;

    assign req_we    = (pick_sel == PORT_CORE) ? we0    : we1;
    assign req_addr  = (pick_sel == PORT_CORE) ? addr0  : addr1;
    assign req_wdata = (pick_sel == PORT_CORE) ? wdata0 : wdata1;
    assign req_err   = ((req_addr[1:0] & ALIGN_MASK) != '0) ||
                       ({1'b0, req_addr[ADDR_W-1:2]} >= DEPTH_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_any) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            owner_q <= PORT_CORE;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (grant) begin
                we_q    <= req_we;
                err_q   <= req_err;
                owner_q <= pick_sel;
                idx_q   <= req_addr[ADDR_W-1:2];
                wdata_q <= req_wdata;
            end
            if (state == ACCESS)
                rdata_q <= (we_q || err_q) ? '0 : mem_data_out;
        end
    end

`ifdef DMEM_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     last <= PORT_LOADER;
        else if (grant) last <= pick_sel;
    end
`else
    assign last = PORT_LOADER;
`endif

    // gnt is combinational from req, so it is also gated by reset to keep outputs at 0.
    always_comb begin
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        rvalid0     = 1'b0;
        rvalid1     = 1'b0;
        rdata0      = '0;
        rdata1      = '0;
        err0        = 1'b0;
        err1        = 1'b0;
        mem_address = '0;
        mem_wr_en   = 1'b0;
        mem_read_en = 1'b0;
        mem_wr_data = '0;
        case (state)
            IDLE: begin
                if (pick_any && rst_n) begin
                    gnt0 = (pick_sel == PORT_CORE);
                    gnt1 = (pick_sel == PORT_LOADER);
                end
            end
            ACCESS: begin
                mem_address = 32'(idx_q);
                if (!err_q) begin
                    mem_wr_en   = we_q;
                    mem_read_en = ~we_q;
                    if (we_q) mem_wr_data = wdata_q;
                end
            end
            RESP: begin
                if (owner_q == PORT_CORE) begin
                    rvalid0 = 1'b1;
                    rdata0  = rdata_q;
                    err0    = err_q;
                end else begin
                    rvalid1 = 1'b1;
                    rdata1  = rdata_q;
                    err1    = err_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter against a transaction-level model.
// Honours DMEM_ARB_RR_EN for the expected tie-breaking rule.
module tb_dmem_arbiter;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [DW-1:0] rdata0, rdata1;
    logic [31:0]   mem_address;
    logic          mem_wr_en, mem_read_en;
    logic [DW-1:0] mem_wr_data, mem_data_out;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .mem_address(mem_address), .mem_wr_en(mem_wr_en), .mem_read_en(mem_read_en),
        .mem_wr_data(mem_wr_data), .mem_data_out(mem_data_out)
    );

    // Stand-in for data_mem: combinational read, write on the clock edge.
    function automatic logic [31:0] init_pat(int unsigned i);
        return (i == 5) ? 32'h0000_1234 : (32'hC0DE_0000 + i * 7);
    endfunction

    logic [31:0] env_mem [DEPTH];
    bit          written [DEPTH];
    logic [7:0]  env_idx;
    assign env_idx = mem_address[7:0];

    always @(posedge clk) begin
        if (mem_wr_en && mem_address < DEPTH) begin
            env_mem[env_idx] <= mem_wr_data;
            written[env_idx] <= 1'b1;
        end
    end

    always_comb begin
        if (mem_address < DEPTH)
            mem_data_out = written[env_idx] ? env_mem[env_idx] : init_pat(32'(env_idx));
        else
            mem_data_out = '0;
    end

    // Transaction-level reference model
    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    req_t        q0[$], q1[$];
    req_t        cur0, cur1;
    bit          pend0, pend1;
    logic [31:0] ref_mem [DEPTH];
    int          cyc, free_at;
    bit          last_m;
    bit          idle_gaps;
    int          dut_log[$];

    bit          fl_v, fl_port, fl_we, fl_err;
    int          fl_g;
    logic [31:0] fl_idx, fl_wdata, fl_rdata;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit          grant_now, winner;
        bit          e_we, e_re, e_rv0, e_rv1, e_er0, e_er1;
        logic [31:0] e_addr, e_wd, e_rd0, e_rd1;
        req_t        r;
        if (!pend0 && q0.size() > 0 && !(idle_gaps && $urandom_range(0, 2) == 0)) begin
            cur0 = q0.pop_front(); pend0 = 1'b1;
        end
        if (!pend1 && q1.size() > 0 && !(idle_gaps && $urandom_range(0, 2) == 0)) begin
            cur1 = q1.pop_front(); pend1 = 1'b1;
        end
        req0 = pend0; we0 = cur0.we; addr0 = cur0.addr; wdata0 = cur0.wdata;
        req1 = pend1; we1 = cur1.we; addr1 = cur1.addr; wdata1 = cur1.wdata;

        grant_now = (cyc >= free_at) && (pend0 || pend1);
        if (pend0 && pend1) begin
`ifdef DMEM_ARB_RR_EN
            winner = !last_m;
`else
            winner = 1'b0;
`endif
        end else begin
            winner = pend0 ? 1'b0 : 1'b1;
        end

        {e_we, e_re, e_rv0, e_rv1, e_er0, e_er1} = '0;
        e_addr = '0; e_wd = '0; e_rd0 = '0; e_rd1 = '0;
        if (fl_v && cyc == fl_g + 1) begin
            e_addr = fl_idx;
            if (!fl_err) begin
                e_we = fl_we; e_re = !fl_we; e_wd = fl_wdata;
            end
        end
        if (fl_v && cyc == fl_g + 2) begin
            if (fl_port == 1'b0) begin
                e_rv0 = 1'b1; e_er0 = fl_err; e_rd0 = (fl_err || fl_we) ? '0 : fl_rdata;
            end else begin
                e_rv1 = 1'b1; e_er1 = fl_err; e_rd1 = (fl_err || fl_we) ? '0 : fl_rdata;
            end
        end

        @(negedge clk);
        chk($sformatf("gnt0@%0d", cyc), 32'(gnt0), 32'(grant_now && !winner));
        chk($sformatf("gnt1@%0d", cyc), 32'(gnt1), 32'(grant_now && winner));
        chk($sformatf("mem_wr_en@%0d", cyc), 32'(mem_wr_en), 32'(e_we));
        chk($sformatf("mem_read_en@%0d", cyc), 32'(mem_read_en), 32'(e_re));
        chk($sformatf("mem_address@%0d", cyc), mem_address, e_addr);
        if (e_we) chk($sformatf("mem_wr_data@%0d", cyc), mem_wr_data, e_wd);
        chk($sformatf("rvalid0@%0d", cyc), 32'(rvalid0), 32'(e_rv0));
        chk($sformatf("rvalid1@%0d", cyc), 32'(rvalid1), 32'(e_rv1));
        chk($sformatf("rdata0@%0d", cyc), rdata0, e_rd0);
        chk($sformatf("rdata1@%0d", cyc), rdata1, e_rd1);
        chk($sformatf("err0@%0d", cyc), 32'(err0), 32'(e_er0));
        chk($sformatf("err1@%0d", cyc), 32'(err1), 32'(e_er1));
        if (gnt0) dut_log.push_back(0);
        if (gnt1) dut_log.push_back(1);

        if (grant_now) begin
            r        = winner ? cur1 : cur0;
            fl_v     = 1'b1;
            fl_g     = cyc;
            fl_port  = winner;
            fl_we    = r.we;
            fl_err   = (r.addr % 4 != 0) || (r.addr / 4 >= DEPTH);
            fl_idx   = r.addr / 4;
            fl_wdata = r.wdata;
            fl_rdata = '0;
            if (!fl_err) begin
                if (r.we) ref_mem[fl_idx[7:0]] = r.wdata;
                else      fl_rdata = ref_mem[fl_idx[7:0]];
            end
            free_at = cyc + 3;
            last_m  = winner;
            if (winner) pend1 = 1'b0; else pend0 = 1'b0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(string tag, int max_cycles);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || pend0 || pend1 || cyc < free_at) && n < max_cycles) begin
            tick();
            n++;
        end
        vectors++;
        assert (n < max_cycles) else begin
            miscompares++;
            $error("FAIL timeout_%s: observed %0d cycles required < %0d", tag, n, max_cycles);
        end
    endtask

    function automatic req_t mk(bit we, logic [31:0] addr, logic [31:0] wdata);
        req_t r;
        r.we = we; r.addr = addr; r.wdata = wdata;
        return r;
    endfunction

    task automatic model_reset();
        pend0 = 1'b0; pend1 = 1'b0;
        q0.delete(); q1.delete();
        fl_v = 1'b0; free_at = cyc; last_m = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish required finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int exp_order[4];
        logic [31:0] a;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_pat(i);
        cur0 = mk(1'b0, '0, '0); cur1 = mk(1'b0, '0, '0);
        cyc = 0; idle_gaps = 1'b0;
        model_reset();

        // Reset state, with a request already pending
        rst_n = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h14; wdata0 = '0;
        req1 = 1'b1; we1 = 1'b1; addr1 = '0;    wdata1 = '0;
        #12;
        chk("rst_gnt0", 32'(gnt0), 32'd0);
        chk("rst_gnt1", 32'(gnt1), 32'd0);
        chk("rst_mem_enables", {30'd0, mem_wr_en, mem_read_en}, 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_rvalid", {30'd0, rvalid0, rvalid1}, 32'd0);
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Contention: both ports keep requesting for four accesses
        q0.push_back(mk(1'b0, 32'h0, '0)); q0.push_back(mk(1'b0, 32'h4, '0));
        q1.push_back(mk(1'b0, 32'h8, '0)); q1.push_back(mk(1'b0, 32'hC, '0));
        dut_log.delete();
        drain("contention", 40);
`ifdef DMEM_ARB_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 1, 1};
`endif
        chk("contention_grants", 32'(dut_log.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < dut_log.size())
                chk($sformatf("contention_order%0d", i), 32'(dut_log[i]), 32'(exp_order[i]));

        // Read hit, write then read, error cases
        q0.push_back(mk(1'b0, 32'h14, '0));
        drain("read_hit", 20);
        q1.push_back(mk(1'b1, 32'h20, 32'h0000_DEAD));
        q1.push_back(mk(1'b0, 32'h20, '0));
        drain("write_read", 20);
        q0.push_back(mk(1'b0, 32'h2, '0));
        q0.push_back(mk(1'b1, 32'h400, 32'h5555_AAAA));
        q1.push_back(mk(1'b0, 32'h3FC, '0));
        drain("errors", 30);

        // Reset during the ACCESS cycle of a write
        q0.push_back(mk(1'b1, 32'h320, 32'hBADC_0FFE));
        tick();
        @(negedge clk);
        chk("mid_rst_wr_en_before", 32'(mem_wr_en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_en", 32'(mem_wr_en), 32'd0);
        chk("mid_rst_rd_en", 32'(mem_read_en), 32'd0);
        chk("mid_rst_address", mem_address, 32'd0);
        chk("mid_rst_outputs", {28'd0, gnt0, gnt1, rvalid0, rvalid1}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc += 2;
        model_reset();
        q0.push_back(mk(1'b0, 32'h10, '0));
        dut_log.delete();
        tick();
        chk("post_rst_first_grant", 32'(dut_log.size()), 32'd1);
        drain("post_rst", 20);

        // Randomized traffic on both ports
        idle_gaps = 1'b1;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 7))
                0:       a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
                1:       a = 32'($urandom_range(256, 1023)) * 4;
                default: a = 32'($urandom_range(0, 63)) * 4;
            endcase
            if (i % 2 == 0) q0.push_back(mk(1'($urandom_range(0, 1)), a, $urandom));
            else            q1.push_back(mk(1'($urandom_range(0, 1)), a, $urandom));
        end
        drain("random", 2000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
